fp_adder_seq: RTL and testbench

FP_ADDER_SEQ -- requirements
Module: fp_adder_seq

---
 rtl/fp_adder_seq.sv | 195 +++++++++++++++++++
 tb/tb_fp_adder_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_seq.sv
// fp_adder_seq: multi-cycle floating-point adder sequenced IDLE -> ALIGN -> ADD -> NORM -> DONE.
// Build option FP_ADD_ROUND_EN keeps one guard bit and rounds half-up; without it, shifted-out bits are truncated.
module fp_adder_seq #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sign1,
  input  logic              sign2,
  input  logic [EXP_W-1:0]  exp1,
  input  logic [EXP_W-1:0]  exp2,
  input  logic [FRAC_W-1:0] frac1,
  input  logic [FRAC_W-1:0] frac2,
  output logic              ready,
  output logic              done_tick,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [FRAC_W-1:0] frac_out,
  output logic              overflow
);

`ifdef FP_ADD_ROUND_EN
  localparam int GW = 1;
`else
  localparam int GW = 0;
`endif
  localparam int MW = FRAC_W + GW;
  localparam logic [EXP_W-1:0]  EXP_MAX  = '1;
  localparam logic [FRAC_W-1:0] FRAC_MAX = '1;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state;

  logic              eff_sub;
  logic              sign_b;
  logic [EXP_W-1:0]  exp_b;
  logic [EXP_W-1:0]  exp_s;
  logic [MW-1:0]     mant_b;
  logic [MW-1:0]     mant_s;
  logic              w_sign;
  logic              w_ovf;
  logic [EXP_W-1:0]  w_exp;
  logic [MW-1:0]     w_mant;

  logic              op1_big;
  logic [EXP_W-1:0]  exp_diff;
  logic [MW:0]       sum;
  logic              norm_shift;
  logic [EXP_W-1:0]  fin_exp;
  logic [FRAC_W-1:0] fin_frac;
  logic              fin_ovf;

  function automatic logic exp_saturates(input logic [EXP_W-1:0] e);
    return e == EXP_MAX;
  endfunction

`ifdef FP_ADD_ROUND_EN
  function automatic logic [FRAC_W:0] round_half_up(input logic [MW-1:0] m);
    return {1'b0, m[MW-1:1]} + {{FRAC_W{1'b0}}, m[0]};
  endfunction

  logic [FRAC_W:0] rnd;
`endif

  always_comb begin
    op1_big    = {exp1, frac1} >= {exp2, frac2};
    exp_diff   = exp_b - exp_s;
    sum        = eff_sub ? ({1'b0, mant_b} - {1'b0, mant_s})
                         : ({1'b0, mant_b} + {1'b0, mant_s});
    norm_shift = !w_ovf && !w_mant[MW-1] && (w_exp != '0);
`ifdef FP_ADD_ROUND_EN
    rnd      = round_half_up(w_mant);
    fin_exp  = w_exp;
    fin_frac = rnd[FRAC_W-1:0];
    fin_ovf  = w_ovf;
    if (w_ovf) begin
      fin_frac = FRAC_MAX;
    end else if (rnd[FRAC_W]) begin
      if (exp_saturates(w_exp)) begin
        fin_exp  = EXP_MAX;
        fin_frac = FRAC_MAX;
        fin_ovf  = 1'b1;
      end else begin
        fin_exp  = w_exp + 1'b1;
        fin_frac = rnd[FRAC_W:1];
      end
    end
`else
    fin_exp  = w_exp;
    fin_frac = w_mant;
    fin_ovf  = w_ovf;
`endif
  end

  // Working datapath: operands are captured on acceptance and only meaningful while busy.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          eff_sub <= sign1 ^ sign2;
          if (op1_big) begin
            sign_b <= sign1;
            exp_b  <= exp1;
            exp_s  <= exp2;
            mant_b <= MW'(frac1) << GW;
            mant_s <= MW'(frac2) << GW;
          end else begin
            sign_b <= sign2;
            exp_b  <= exp2;
            exp_s  <= exp1;
            mant_b <= MW'(frac2) << GW;
            mant_s <= MW'(frac1) << GW;
          end
        end
      end
      ALIGN: begin
        if (int'(exp_diff) >= FRAC_W + 1) mant_s <= '0;
        else                              mant_s <= mant_s >> exp_diff;
      end
      ADD: begin
        w_sign <= sign_b;
        w_exp  <= exp_b;
        w_mant <= sum[MW-1:0];
        w_ovf  <= 1'b0;
        if (sum[MW]) begin
          if (exp_saturates(exp_b)) begin
            w_exp  <= EXP_MAX;
            w_mant <= '1;
            w_ovf  <= 1'b1;
          end else begin
            w_exp  <= exp_b + 1'b1;
            w_mant <= sum[MW:1];
          end
        end else if (sum == '0) begin
          w_sign <= 1'b0;
          w_exp  <= '0;
        end
      end
      NORM: begin
        if (norm_shift) begin
          w_mant <= w_mant << 1;
          w_exp  <= w_exp - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control FSM. Carry, saturated and zero sums also pass through NORM, which exits at once for
  // them, so every result sees the same 4-cycle base latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      sign_out  <= 1'b0;
      exp_out   <= '0;
      frac_out  <= '0;
      overflow  <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ready <= 1'b0;
            state <= ALIGN;
          end
        end
        ALIGN: state <= ADD;
        ADD:   state <= NORM;
        NORM: begin
          if (!norm_shift) begin
            state     <= DONE;
            done_tick <= 1'b1;
            sign_out  <= w_sign;
            exp_out   <= fin_exp;
            frac_out  <= fin_frac;
            overflow  <= fin_ovf;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder_seq.sv
// tb_fp_adder_seq: directed and randomized operations on fp_adder_seq (EXP_W=4, FRAC_W=8),
// compared each cycle against an arithmetic model of the add, normalise and round rules.
module tb_fp_adder_seq;
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;
`ifdef FP_ADD_ROUND_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam int FMAX = (1 << FRAC_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              sign1 = 1'b0;
  logic              sign2 = 1'b0;
  logic [EXP_W-1:0]  exp1 = '0;
  logic [EXP_W-1:0]  exp2 = '0;
  logic [FRAC_W-1:0] frac1 = '0;
  logic [FRAC_W-1:0] frac2 = '0;
  logic              ready;
  logic              done_tick;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [FRAC_W-1:0] frac_out;
  logic              overflow;

  fp_adder_seq #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2), .frac1(frac1), .frac2(frac2),
    .ready(ready), .done_tick(done_tick), .sign_out(sign_out),
    .exp_out(exp_out), .frac_out(frac_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    bit s;
    int e;
    int f;
    bit ov;
    int lat;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Value-level reference: align as an integer division, add/subtract, normalise, round.
  function automatic res_t model(bit s1, int e1, int f1, bit s2, int e2, int f2);
    res_t r;
    bit sb, ss;
    int eb, es, fb, fs, e, n;
    longint v, sm, top;
    if (e1 * (FMAX + 1) + f1 >= e2 * (FMAX + 1) + f2) begin
      sb = s1; eb = e1; fb = f1; ss = s2; es = e2; fs = f2;
    end else begin
      sb = s2; eb = e2; fb = f2; ss = s1; es = e1; fs = f1;
    end
    top = longint'(1) << (FRAC_W + G);
    sm  = (eb - es >= FRAC_W + 1) ? 0 : ((longint'(fs) << G) >> (eb - es));
    v   = (sb == ss) ? (longint'(fb) << G) + sm : (longint'(fb) << G) - sm;
    r.s = sb; r.ov = 1'b0; r.lat = 4; e = eb; n = 0;
    if (v == 0) begin
      r.s = 1'b0; r.e = 0; r.f = 0;
      return r;
    end
    if (v >= top) begin
      if (eb == EMAX) begin
        r.e = EMAX; r.f = FMAX; r.ov = 1'b1;
        return r;
      end
      v = v / 2;
      e = eb + 1;
    end else begin
      while (v < top / 2 && e > 0) begin
        v = v * 2; e--; n++;
      end
    end
    r.lat = 4 + n;
    if (G == 1) begin
      v = v / 2 + v % 2;
      if (v > FMAX) begin
        if (e == EMAX) begin
          r.e = EMAX; r.f = FMAX; r.ov = 1'b1;
          return r;
        end
        v = v / 2;
        e++;
      end
    end
    r.e = e;
    r.f = int'(v);
    return r;
  endfunction

  bit   m_idle = 1'b1;
  bit   m_done = 1'b0;
  int   m_t = 0;
  res_t m_cur;
  res_t m_held;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      m_idle = 1'b1;
      m_done = 1'b0;
      m_held.s = 1'b0; m_held.e = 0; m_held.f = 0; m_held.ov = 1'b0; m_held.lat = 0;
    end else if (m_idle) begin
      m_done = 1'b0;
      if (start) begin
        m_cur  = model(sign1, int'(exp1), int'(frac1), sign2, int'(exp2), int'(frac2));
        m_t    = 1;
        m_idle = 1'b0;
      end
    end else begin
      m_t++;
      m_done = (m_t == m_cur.lat);
      if (m_done) m_held = m_cur;
      if (m_t == m_cur.lat + 1) m_idle = 1'b1;
    end
    chk("ready",     32'(ready),     32'(m_idle));
    chk("done_tick", 32'(done_tick), 32'(m_done));
    chk("sign_out",  32'(sign_out),  32'(m_held.s));
    chk("exp_out",   32'(exp_out),   32'(m_held.e));
    chk("frac_out",  32'(frac_out),  32'(m_held.f));
    chk("overflow",  32'(overflow),  32'(m_held.ov));
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (!m_idle && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!m_idle) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", k);
    end
  endtask

  task automatic do_op(input bit s1, input int e1, input int f1, input bit s2, input int e2, input int f2);
    wait_idle();
    sign1 = s1; exp1 = e1[EXP_W-1:0]; frac1 = f1[FRAC_W-1:0];
    sign2 = s2; exp2 = e2[EXP_W-1:0]; frac2 = f2[FRAC_W-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int rfrac();
    if ($urandom_range(0, 15) == 0) return 0;
    return int'($urandom_range(FMAX / 2 + 1, FMAX));
  endfunction

  initial begin
    res_t r;
    bit s1, s2;
    int e1, e2, f1, f2;

    r = model(0, 8, 'hB5, 0, 8, 'h80);
    chk("lit030_exp", 32'(r.e), 32'd9);
    chk("lit030_frac", 32'(r.f), (G == 1) ? 32'h9B : 32'h9A);
    chk("lit030_sign", 32'(r.s), 32'd0);
    chk("lit030_ovf", 32'(r.ov), 32'd0);
    chk("lit030_lat", 32'(r.lat), 32'd4);
    r = model(0, 8, 'h80, 1, 8, 'h80);
    chk("lit031_exp", 32'(r.e), 32'd0);
    chk("lit031_frac", 32'(r.f), 32'h00);
    chk("lit031_lat", 32'(r.lat), 32'd4);
    r = model(0, 8, 'h80, 1, 7, 'hFE);
    chk("lit032_exp", 32'(r.e), 32'd1);
    chk("lit032_frac", 32'(r.f), 32'h80);
    chk("lit032_lat", 32'(r.lat), 32'd11);
    r = model(0, 15, 'hFF, 0, 15, 'hFF);
    chk("lit033_exp", 32'(r.e), 32'hF);
    chk("lit033_frac", 32'(r.f), 32'hFF);
    chk("lit033_ovf", 32'(r.ov), 32'd1);
    r = model(0, 12, 'h80, 0, 1, 'hFF);
    chk("lit033b_exp", 32'(r.e), 32'd12);
    chk("lit033b_frac", 32'(r.f), 32'h80);
    chk("lit033b_ovf", 32'(r.ov), 32'd0);

    repeat (3) @(negedge clk);
    reset = 1'b0;

    do_op(0, 8, 'hB5, 0, 8, 'h80);
    do_op(0, 8, 'h80, 1, 8, 'h80);
    do_op(0, 8, 'h80, 1, 7, 'hFE);
    do_op(0, 15, 'hFF, 0, 15, 'hFF);
    do_op(0, 12, 'h80, 0, 1, 'hFF);
    do_op(1, 8, 'h80, 0, 8, 'h80);
    do_op(0, 3, 'h90, 1, 3, 'hA0);

    do_op(1, 5, 'hC0, 0, 3, 'hA0);
    repeat (4) begin
      start = 1'b1;
      sign1 = ~sign1;
      exp1  = exp1 + 1'b1;
      @(negedge clk);
    end
    start = 1'b0;

    do_op(0, 8, 'h80, 1, 7, 'hFE);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 250; i++) begin
      s1 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      e1 = int'($urandom_range(0, EMAX));
      if ($urandom_range(0, 3) == 0) e2 = int'($urandom_range(0, EMAX));
      else e2 = e1 - int'($urandom_range(0, 2));
      if (e2 < 0) e2 = 0;
      f1 = rfrac();
      f2 = rfrac();
      if (f1 == 0) e1 = 0;
      if (f2 == 0) e2 = 0;
      if ($urandom_range(0, 1) == 1) do_op(s1, e1, f1, s2, e2, f2);
      else                           do_op(s2, e2, f2, s1, e1, f1);
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          start = 1'b1;
          sign2 = ~sign2;
          @(negedge clk);
        end
        start = 1'b0;
      end
    end

    wait_idle();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
